fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder: holds the PC, issues word reads to

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch/decode front end: opcodes, fetch FSM states, widths.
package riscv_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {FETCH, FLUSH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: registered write, head read straight from storage, flush clears.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full buffer still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, fetch buffer, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect target sets sticky fetch_misalign and halts.
module fetch_unit import riscv_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [XLEN-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               fetch_misalign
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  fetch_state_t state, state_n, resume;
  logic [XLEN-1:0]                  pc, tgt;
  logic [CW-1:0]                    outstanding, out_n, drop, drop_n, fcount, cnt_n;
  logic [FIFO_DEPTH-1:0][XLEN-1:0]  pcq;
  logic [AW-1:0]                    pq_wp, pq_rp;
  logic                             accept, live_resp, pop_ok, req_valid_n, trap_n;
  logic                             fempty, ffull_unused;
  fetch_entry_t                     wentry, head;

  assign accept    = imem_req_valid && imem_req_ready;
  // responses in FLUSH, or in a redirect cycle, are stale and never reach the buffer
  assign live_resp = imem_resp_valid && (state == FETCH) && !redirect_valid;
  assign pop_ok    = instr_ready && !fempty;
  assign imem_addr = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign tgt            = redirect_pc;
  assign trap_n         = misalign_q | (redirect_valid & (|redirect_pc[1:0]));
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= trap_n;
  end
`else
  logic unused_low;
  assign tgt            = {redirect_pc[XLEN-1:2], 2'b00};
  assign trap_n         = 1'b0;
  assign fetch_misalign = 1'b0;
  assign unused_low     = ^redirect_pc[1:0];
`endif

  assign resume = trap_n ? HALT : FETCH;

  always_comb begin
    state_n = state;
    out_n   = outstanding;
    drop_n  = drop;
    cnt_n   = fcount;
    if (redirect_valid) begin
      cnt_n = '0;
      out_n = '0;
      if (state == FLUSH) drop_n = drop - CW'(imem_resp_valid);
      else                drop_n = outstanding + CW'(accept) - CW'(imem_resp_valid);
      state_n = (drop_n != '0) ? FLUSH : resume;
    end else begin
      case (state)
        FETCH: begin
          out_n = outstanding + CW'(accept) - CW'(live_resp);
          cnt_n = fcount + CW'(live_resp) - CW'(pop_ok);
        end
        FLUSH: begin
          drop_n = drop - CW'(imem_resp_valid);
          if (drop_n == '0) state_n = resume;
        end
        default: ;
      endcase
    end
    // registered request valid: same credit rule, evaluated on next-cycle state
    req_valid_n = (state_n == FETCH) &&
                  (({1'b0, out_n} + {1'b0, cnt_n}) < (CW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      outstanding    <= '0;
      drop           <= '0;
      imem_req_valid <= 1'b0;
      pcq            <= '0;
      pq_wp          <= '0;
      pq_rp          <= '0;
    end else begin
      state          <= state_n;
      outstanding    <= out_n;
      drop           <= drop_n;
      imem_req_valid <= req_valid_n;
      if (redirect_valid) begin
        pc    <= tgt;
        pq_wp <= '0;
        pq_rp <= '0;
      end else begin
        if (accept) begin
          pc         <= pc + XLEN'(PC_STEP);
          pcq[pq_wp] <= pc;
          pq_wp      <= pq_wp + 1'b1;
        end
        if (live_resp) pq_rp <= pq_rp + 1'b1;
      end
    end
  end

  assign wentry = '{instr: imem_resp_data, pc: pcq[pq_rp]};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W + XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (live_resp),
    .pop   (instr_ready),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .count (fcount),
    .full  (ffull_unused),
    .empty (fempty)
  );

  assign instr_valid = !fempty;
  assign instruction = head.instr;
  assign instr_pc    = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: behavioural imem with latency, PC model, redirect scenarios.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] cons_pc[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 1, n_acc = 0, n_cons = 0, first_acc = -1, first_vld = -1;
  bit          rnd_rdy = 0, mem_rdy = 1, dec_rdy = 1, redir_now = 0, redir_arm = 0, fired = 0;
  logic [31:0] redir_tgt = '0, mpc = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // One clock: drive memory/decoder/redirect at negedge, score outputs, advance to posedge+1.
  task automatic step();
    bit fire, acc;
    @(negedge clk);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memword(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    imem_req_ready = mem_rdy && (!rnd_rdy || ($urandom_range(0, 1) == 1));
    instr_ready    = dec_rdy && (!rnd_rdy || ($urandom_range(0, 3) != 0));
    acc  = imem_req_valid && imem_req_ready;
    fire = redir_now || (redir_arm && imem_resp_valid && acc);
    redirect_valid = fire;
    redirect_pc    = redir_tgt;
    if (instr_valid && first_vld < 0) first_vld = cyc;
    if (instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: instr_pc=%h instruction=%h but nothing expected", instr_pc, instruction);
      end else begin
        if (instruction !== exp_q[0].data || instr_pc !== exp_q[0].pc) begin
          failures++;
          $display("FAIL sb_instr: got %h@%h expected %h@%h", instruction, instr_pc,
                   exp_q[0].data, exp_q[0].pc);
        end
        exp_q.delete(0);
      end
      cons_pc.push_back(instr_pc);
      n_cons++;
    end
    if (acc) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      checks++;
      if (imem_addr !== mpc) begin
        failures++;
        $display("FAIL req_addr: imem_addr=%h expected %h", imem_addr, mpc);
      end
      pend.push_back('{imem_addr, cyc + lat});
      if (!fire) begin
        exp_q.push_back('{memword(mpc), mpc});
        mpc = mpc + 32'd4;
      end
    end
    if (fire) begin
      exp_q.delete();
      cons_pc.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      mpc = redir_tgt;
`else
      mpc = {redir_tgt[31:2], 2'b00};
`endif
      redir_now = 0;
      redir_arm = 0;
      fired     = 1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; imem_req_ready = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    redir_now = 0; redir_arm = 0; fired = 0; rnd_rdy = 0; mem_rdy = 1; dec_rdy = 1;
    pend.delete(); exp_q.delete(); cons_pc.delete();
    mpc = 32'h0; lat = l; n_acc = 0; first_acc = -1; first_vld = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain_stale(input logic [31:0] target);
    int bad = 0;
    for (int i = 0; i < 20 && pend.size() > 0; i++) begin
      if (imem_req_valid) bad++;
      step();
    end
    checks++;
    if (bad != 0 || pend.size() != 0) begin
      failures++;
      $display("FAIL flush_hold: early requests=%0d stale left=%0d required 0/0", bad, pend.size());
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== target) begin
      failures++;
      $display("FAIL flush_resume: req_valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, target);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, fetch_misalign, instruction, instr_pc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rv=%b iv=%b mis=%b instr=%h pc=%h required all 0",
               imem_req_valid, instr_valid, fetch_misalign, instruction, instr_pc);
    end
    do_reset(1);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_req: rv=%b addr=%h iv=%b required 1 0 0", imem_req_valid, imem_addr, instr_valid);
    end
  endtask

  task automatic test_stream();
    do_reset(1);
    for (int i = 0; i < 40 && cons_pc.size() < 4; i++) step();
    checks++;
    if (cons_pc.size() < 4 || cons_pc[0] !== 32'h0 || cons_pc[1] !== 32'h4 ||
        cons_pc[2] !== 32'h8 || cons_pc[3] !== 32'hC) begin
      failures++;
      $display("FAIL stream_order: got %0d pcs, required 0,4,8,12", cons_pc.size());
    end
    checks++;
    if (first_vld - first_acc != lat + 1) begin
      failures++;
      $display("FAIL stream_latency: accept->valid=%0d required %0d", first_vld - first_acc, lat + 1);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    dec_rdy = 0;
    repeat (10) step();
    checks++;
    if (n_acc != 2 || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_credit: requests=%0d iv=%b rv=%b required 2 1 0", n_acc, instr_valid, imem_req_valid);
    end
    dec_rdy = 1;
    for (int i = 0; i < 30 && cons_pc.size() < 3; i++) step();
    checks++;
    if (cons_pc.size() < 3 || cons_pc[0] !== 32'h0 || cons_pc[1] !== 32'h4 || cons_pc[2] !== 32'h8) begin
      failures++;
      $display("FAIL bp_release: got %0d pcs, required 0,4,8", cons_pc.size());
    end
  endtask

  task automatic test_redirect_flush();
    do_reset(3);
    for (int i = 0; i < 20 && pend.size() < 2; i++) step();
    redir_tgt = 32'h100;
    redir_now = 1;
    step();
    drain_stale(32'h100);
    for (int i = 0; i < 20 && cons_pc.size() == 0; i++) step();
    checks++;
    if (cons_pc.size() == 0 || cons_pc[0] !== 32'h100) begin
      failures++;
      $display("FAIL redirect_target: first pc=%h required 00000100", cons_pc.size() ? cons_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    do_reset(1);
    redir_tgt = 32'h200;
    redir_arm = 1;
    for (int i = 0; i < 50 && !fired; i++) step();
    checks++;
    if (!fired) begin
      failures++;
      $display("FAIL collide_timeout: no cycle with response+accept, fired=%0d required 1", fired);
    end
    drain_stale(32'h200);
    for (int i = 0; i < 20 && cons_pc.size() == 0; i++) step();
    checks++;
    if (cons_pc.size() == 0 || cons_pc[0] !== 32'h200) begin
      failures++;
      $display("FAIL collide_target: first pc=%h required 00000200", cons_pc.size() ? cons_pc[0] : 32'hx);
    end
  endtask

  task automatic test_reset_in_flush();
    do_reset(3);
    for (int i = 0; i < 20 && pend.size() < 2; i++) step();
    redir_tgt = 32'h300;
    redir_now = 1;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, fetch_misalign, instruction, instr_pc} !== '0) begin
      failures++;
      $display("FAIL flush_reset_outputs: rv=%b iv=%b instr=%h pc=%h required 0", imem_req_valid,
               instr_valid, instruction, instr_pc);
    end
    do_reset(1);
    for (int i = 0; i < 20 && cons_pc.size() == 0; i++) step();
    checks++;
    if (cons_pc.size() == 0 || cons_pc[0] !== 32'h0) begin
      failures++;
      $display("FAIL flush_reset_restart: first pc=%h required 00000000", cons_pc.size() ? cons_pc[0] : 32'hx);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset(2);
    rnd_rdy = 1;
    start = n_cons;
    for (int i = 0; i < 400; i++) begin
      if (!redir_now && $urandom_range(0, 39) == 0) begin
        redir_tgt = 32'($urandom_range(0, 1023)) << 2;
        redir_now = 1;
      end
      step();
    end
    mem_rdy = 0;
    rnd_rdy = 0;
    repeat (30) step();
    checks++;
    if (exp_q.size() != 0 || pend.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: expected left=%0d pending=%0d required 0/0", exp_q.size(), pend.size());
    end
    checks++;
    if (n_cons - start < 40) begin
      failures++;
      $display("FAIL b2b_throughput: consumed=%0d required >=40", n_cons - start);
    end
  endtask

  task automatic test_misalign();
    int bad = 0;
    do_reset(1);
    repeat (6) step();
    redir_tgt = 32'h102;
    redir_now = 1;
    step();
    for (int i = 0; i < 20 && pend.size() > 0; i++) step();
`ifdef FETCH_MISALIGN_TRAP_EN
    step();
    checks++;
    if (fetch_misalign !== 1'b1) begin
      failures++;
      $display("FAIL misalign_flag: fetch_misalign=%b required 1", fetch_misalign);
    end
    repeat (10) begin
      if (imem_req_valid || instr_valid) bad++;
      step();
    end
    checks++;
    if (bad != 0 || fetch_misalign !== 1'b1) begin
      failures++;
      $display("FAIL misalign_halt: active cycles=%0d flag=%b required 0 1", bad, fetch_misalign);
    end
`else
    for (int i = 0; i < 20 && cons_pc.size() == 0; i++) step();
    checks++;
    if (cons_pc.size() == 0 || cons_pc[0] !== 32'h100) begin
      failures++;
      $display("FAIL misalign_mask: first pc=%h required 00000100", cons_pc.size() ? cons_pc[0] : 32'hx);
    end
    checks++;
    if (fetch_misalign !== 1'b0 || bad != 0) begin
      failures++;
      $display("FAIL misalign_tied: fetch_misalign=%b required 0", fetch_misalign);
    end
`endif
  endtask

  initial begin
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_reset_in_flush();
    test_back_to_back();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
